// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer result inputs, per-source stalls and broadcast bus of the CDB arbiter
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 done_alu_1;
    logic                 done_alu_2;
    logic                 done_lsb;
    logic [31:0]          value_alu_1;
    logic [31:0]          value_alu_2;
    logic [31:0]          value_lsb;
    logic [ROB_WIDTH-1:0] tag_alu_1;
    logic [ROB_WIDTH-1:0] tag_alu_2;
    logic [ROB_WIDTH-1:0] tag_lsb;
    logic                 stall_alu_1;
    logic                 stall_alu_2;
    logic                 stall_lsb;
    logic                 cdb_valid;
    logic [31:0]          cdb_value;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [1:0]           cdb_src;

    modport master (
        output done_alu_1, done_alu_2, done_lsb,
        output value_alu_1, value_alu_2, value_lsb,
        output tag_alu_1, tag_alu_2, tag_lsb,
        input  stall_alu_1, stall_alu_2, stall_lsb,
        input  cdb_valid, cdb_value, cdb_tag, cdb_src
    );

    modport slave (
        input  done_alu_1, done_alu_2, done_lsb,
        input  value_alu_1, value_alu_2, value_lsb,
        input  tag_alu_1, tag_alu_2, tag_lsb,
        output stall_alu_1, stall_alu_2, stall_lsb,
        output cdb_valid, cdb_value, cdb_tag, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with per-source result queues
// Optional macro CDB_ARBITER_BYPASS_EN: an empty source's result may go straight onto the bus.
module cdb_arbiter #(
    parameter int ROB_WIDTH = 4,
    parameter int Q_WIDTH   = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clear_signal,
    cdb_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** Q_WIDTH;
    localparam int CW    = Q_WIDTH + 1;
    localparam int EW    = 32 + ROB_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [EW-1:0]        mem_q  [3][DEPTH];
    logic [Q_WIDTH-1:0]   head_q [3];
    logic [Q_WIDTH-1:0]   head_d [3];
    logic [Q_WIDTH-1:0]   tail_q [3];
    logic [Q_WIDTH-1:0]   tail_d [3];
    logic [CW-1:0]        cnt_q  [3];
    logic [CW-1:0]        cnt_d  [3];
    logic [1:0]           rr_q, rr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [31:0]          cdb_value_q, cdb_value_d;
    logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
    logic [1:0]           cdb_src_q, cdb_src_d;

    logic [2:0]           done, full, req, push, pop;
    logic [EW-1:0]        in_entry [3];
    logic                 grant, byp;
    logic [1:0]           win;
    logic [EW-1:0]        win_entry;

    function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    always_comb begin
        done        = {bus.done_lsb, bus.done_alu_2, bus.done_alu_1};
        in_entry[0] = {bus.value_alu_1, bus.tag_alu_1};
        in_entry[1] = {bus.value_alu_2, bus.tag_alu_2};
        in_entry[2] = {bus.value_lsb, bus.tag_lsb};
    end

    always_comb begin
        full = '0;
        req  = '0;
        for (int i = 0; i < 3; i++) begin
            full[i] = (cnt_q[i] == FULL_CNT);
`ifdef CDB_ARBITER_BYPASS_EN
            req[i]  = (cnt_q[i] != '0) || done[i];
`else
            req[i]  = (cnt_q[i] != '0);
`endif
        end
    end

    // Scan from lowest priority to highest so the highest-priority requester is written last.
    always_comb begin
        grant = 1'b0;
        win   = rr_q;
        for (int k = 2; k >= 0; k--) begin
            if (req[rr_add(rr_q, 2'(k))]) begin
                grant = 1'b1;
                win   = rr_add(rr_q, 2'(k));
            end
        end
    end

    always_comb begin
        byp = 1'b0;
`ifdef CDB_ARBITER_BYPASS_EN
        byp = grant && (cnt_q[win] == '0);
`endif
        win_entry = byp ? in_entry[win] : mem_q[win][head_q[win]];
        push = '0;
        pop  = '0;
        for (int i = 0; i < 3; i++) begin
            pop[i]  = grant && !byp && (win == 2'(i));
            push[i] = done[i] && !clear_signal && !full[i] && !(byp && (win == 2'(i)));
        end
    end

    always_comb begin
        rr_d        = rr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_value_d = cdb_value_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < 3; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
        end
        if (rdy_in) begin
            if (clear_signal) begin
                for (int i = 0; i < 3; i++) begin
                    head_d[i] = '0;
                    tail_d[i] = '0;
                    cnt_d[i]  = '0;
                end
                cdb_valid_d = 1'b0;
                rr_d        = 2'd0;
            end else begin
                cdb_valid_d = grant;
                if (grant) begin
                    cdb_value_d = win_entry[EW-1:ROB_WIDTH];
                    cdb_tag_d   = win_entry[ROB_WIDTH-1:0];
                    cdb_src_d   = win;
                    rr_d        = rr_add(win, 2'd1);
                end
                for (int i = 0; i < 3; i++) begin
                    if (push[i]) tail_d[i] = tail_q[i] + 1'b1;
                    if (pop[i])  head_d[i] = head_q[i] + 1'b1;
                    cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rr_q        <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_value_q <= cdb_value_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
            for (int i = 0; i < 3; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_in && rdy_in && push[i]) mem_q[i][tail_q[i]] <= in_entry[i];
        end
    end

    assign bus.stall_alu_1 = full[0];
    assign bus.stall_alu_2 = full[1];
    assign bus.stall_lsb   = full[2];
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_src     = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
    localparam int RW    = 4;
    localparam int QW    = 1;
    localparam int DEPTH = 2 ** QW;
`ifdef CDB_ARBITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int EXP_LAT = BYP ? 1 : 2;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_signal;
    logic          done  [3];
    logic [31:0]   value [3];
    logic [RW-1:0] tag   [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter_if #(.ROB_WIDTH(RW)) bus ();

    cdb_arbiter #(.ROB_WIDTH(RW), .Q_WIDTH(QW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .bus          (bus.slave)
    );

    assign bus.done_alu_1  = done[0];
    assign bus.done_alu_2  = done[1];
    assign bus.done_lsb    = done[2];
    assign bus.value_alu_1 = value[0];
    assign bus.value_alu_2 = value[1];
    assign bus.value_lsb   = value[2];
    assign bus.tag_alu_1   = tag[0];
    assign bus.tag_alu_2   = tag[1];
    assign bus.tag_lsb     = tag[2];

    // Behavioural model: one plain queue of {value, tag} per source.
    logic [RW+31:0] mq [3][$];
    int             m_rr;
    logic           m_valid;
    logic [31:0]    m_value;
    logic [RW-1:0]  m_tag;
    logic [1:0]     m_src;

    int  issued [3];
    int  seen   [3];
    bit  saw_stall0;
    int  obs_src [$];
    int  obs_cyc [$];
    int  obs_tag [$];
    int  obs_val [$];

    bit            auto_en [3];
    int            rate    [3];
    logic [RW-1:0] tag_ctr [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz [3];
        int win;
        int s;
        bit byp;
        logic [RW+31:0] e;
        if (!rst_in) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 0; m_value = 0; m_tag = 0; m_src = 0; m_rr = 0;
        end else if (rdy_in) begin
            if (clear_signal) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
                m_valid = 0;
                m_rr = 0;
            end else begin
                for (int i = 0; i < 3; i++) sz[i] = mq[i].size();
                win = -1;
                byp = 0;
                for (int k = 0; k < 3; k++) begin
                    s = (m_rr + k) % 3;
                    if (win < 0 && (sz[s] > 0 || (BYP && done[s]))) win = s;
                end
                if (win >= 0) begin
                    if (sz[win] > 0) begin
                        e = mq[win].pop_front();
                        m_value = e[RW+31:RW];
                        m_tag = e[RW-1:0];
                    end else begin
                        byp = 1;
                        m_value = value[win];
                        m_tag = tag[win];
                    end
                    m_valid = 1;
                    m_src = 2'(win);
                    m_rr = (win + 1) % 3;
                end else begin
                    m_valid = 0;
                end
                for (int i = 0; i < 3; i++) begin
                    if (done[i] && sz[i] < DEPTH) begin
                        issued[i]++;
                        if (!(byp && win == i)) mq[i].push_back({value[i], tag[i]});
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("cdb_valid", bus.cdb_valid, m_valid);
        chk("cdb_value", bus.cdb_value, m_value);
        chk("cdb_tag", bus.cdb_tag, m_tag);
        chk("cdb_src", bus.cdb_src, m_src);
        chk("stall_alu_1", bus.stall_alu_1, mq[0].size() == DEPTH);
        chk("stall_alu_2", bus.stall_alu_2, mq[1].size() == DEPTH);
        chk("stall_lsb", bus.stall_lsb, mq[2].size() == DEPTH);
        if (bus.cdb_valid === 1'b1) begin
            obs_src.push_back(int'(bus.cdb_src));
            obs_cyc.push_back(cyc);
            obs_tag.push_back(int'(bus.cdb_tag));
            obs_val.push_back(int'(bus.cdb_value));
            if (bus.cdb_src < 2'd3) seen[bus.cdb_src]++;
        end
        if (bus.stall_alu_1 === 1'b1) saw_stall0 = 1;
    endtask

    always @(posedge clk_in) begin
        model_step();
        cyc++;
        #1;
        compare();
    end

    // Randomized producers: a new result is offered only while its queue has room.
    always @(negedge clk_in) begin
        for (int s = 0; s < 3; s++) begin
            if (auto_en[s]) begin
                if (mq[s].size() < DEPTH && $urandom_range(0, 99) < rate[s]) begin
                    done[s] = 1'b1;
                    value[s] = $urandom;
                    tag[s] = tag_ctr[s];
                    tag_ctr[s] = tag_ctr[s] + 1'b1;
                end else begin
                    done[s] = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic set_auto(input bit a0, input bit a1, input bit a2, input int r);
        auto_en[0] = a0; auto_en[1] = a1; auto_en[2] = a2;
        for (int s = 0; s < 3; s++) begin
            rate[s] = r;
            if (!auto_en[s]) done[s] = 1'b0;
        end
    endtask

    initial begin
        int c0, n0, start;
        logic snap_valid;
        logic [31:0] snap_value;
        logic [RW-1:0] snap_tag;
        logic [1:0] snap_src;
        for (int s = 0; s < 3; s++) begin
            done[s] = 0; value[s] = 0; tag[s] = 0;
            auto_en[s] = 0; rate[s] = 0; tag_ctr[s] = 0;
            issued[s] = 0; seen[s] = 0;
        end
        saw_stall0 = 0;
        rst_in = 0; rdy_in = 1; clear_signal = 0;

        // Reset with a result offered: nothing may be enqueued.
        done[0] = 1; value[0] = 32'h1234; tag[0] = 4'h3;
        step(2);
        rst_in = 1; done[0] = 0;
        chk("rst_valid", bus.cdb_valid, 1'b0);
        chk("rst_value", bus.cdb_value, 32'h0);
        chk("rst_stalls", {bus.stall_alu_1, bus.stall_alu_2, bus.stall_lsb}, 3'b000);
        step(3);
        chk("rst_no_entry", obs_src.size(), 0);

        // Single result from ALU2.
        c0 = cyc; n0 = obs_src.size();
        done[1] = 1; value[1] = 32'h0000_00AA; tag[1] = 4'h5;
        step(1);
        done[1] = 0;
        step(3);
        chk("single_count", obs_src.size() - n0, 1);
        chk("single_src", (obs_src.size() > n0) ? obs_src[n0] : 99, 1);
        chk("single_tag", (obs_src.size() > n0) ? obs_tag[n0] : 99, 5);
        chk("single_value", (obs_src.size() > n0) ? obs_val[n0] : 99, 32'hAA);
        chk("single_latency", (obs_src.size() > n0) ? obs_cyc[n0] - c0 : 99, EXP_LAT);

        // Clear while three entries are queued, coinciding with a grant.
        for (int s = 0; s < 3; s++) begin
            done[s] = 1; value[s] = 32'h100 + s; tag[s] = 4'(7 + s);
        end
        step(1);
        for (int s = 0; s < 3; s++) done[s] = 0;
        clear_signal = 1;
        n0 = obs_src.size();
        step(1);
        clear_signal = 0;
        chk("clear_valid", bus.cdb_valid, 1'b0);
        step(4);
        chk("clear_no_stale", obs_src.size() - n0, 0);
        n0 = obs_src.size();
        done[0] = 1; value[0] = 32'hA0; tag[0] = 4'hA;
        done[2] = 1; value[2] = 32'hB0; tag[2] = 4'hB;
        step(1);
        done[0] = 0; done[2] = 0;
        step(3);
        chk("clear_rr_first", (obs_src.size() > n0) ? obs_src[n0] : 99, 0);
        chk("clear_rr_tag", (obs_src.size() > n0) ? obs_tag[n0] : 99, 4'hA);
        chk("clear_rr_second", (obs_src.size() > n0 + 1) ? obs_src[n0 + 1] : 99, 2);

        // Round robin with all three sources continuously requesting.
        clear_signal = 1;
        step(1);
        clear_signal = 0;
        start = obs_src.size();
        set_auto(1, 1, 1, 100);
        step(12);
        set_auto(0, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            chk("rr_order", (obs_src.size() > start + k) ? obs_src[start + k] : 99, k % 3);
        chk("rr_back_to_back", (obs_src.size() > start + 5) ? obs_cyc[start + 5] - obs_cyc[start] : 99, 5);
        step(8);

        // Back-pressure: ALU1 and LSB every cycle into depth-2 queues.
        for (int s = 0; s < 3; s++) begin issued[s] = 0; seen[s] = 0; end
        saw_stall0 = 0;
        set_auto(1, 0, 1, 100);
        step(40);
        set_auto(0, 0, 0, 0);
        step(10);
        chk("bp_stall_seen", saw_stall0, 1'b1);
        chk("bp_alu1_all", seen[0], issued[0]);
        chk("bp_lsb_all", seen[2], issued[2]);
        chk("bp_alu2_none", seen[1], 0);
        chk("bp_alu1_traffic", issued[0] > 20, 1'b1);

        // Pause mid-stream.
        set_auto(1, 1, 1, 60);
        step(20);
        snap_valid = m_valid; snap_value = m_value; snap_tag = m_tag; snap_src = m_src;
        rdy_in = 0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("pause_valid", bus.cdb_valid, snap_valid);
            chk("pause_value", bus.cdb_value, snap_value);
            chk("pause_tag", bus.cdb_tag, snap_tag);
            chk("pause_src", bus.cdb_src, snap_src);
        end
        rdy_in = 1;
        step(20);

        // Random traffic with occasional pauses and flushes.
        for (int k = 0; k < 300; k++) begin
            if (k % 30 == 0) begin
                set_auto(1, 1, 1, 0);
                for (int s = 0; s < 3; s++) rate[s] = $urandom_range(0, 100);
            end
            rdy_in = ($urandom_range(0, 99) >= 8);
            clear_signal = ($urandom_range(0, 99) < 3);
            step(1);
        end
        set_auto(0, 0, 0, 0);
        rdy_in = 1; clear_signal = 0;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
